// File: rtl/mac_seq_pkg.sv
// Shared state encoding and constants for the 4-bit MAC sequencer.
package mac_seq_pkg;

    localparam int MULTI_WIDTH = 4;
    localparam int OUT_SEL_MAX = 16;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WAIT,
        SAMPLE,
        RESULT
    } seq_state_e;

endpackage

// File: rtl/mac_4bit_seq.sv
// Sequences framed operand/coef terms into the MAC slice and returns one result per frame.
// Latency: single-term frame accepted in cycle 0 -> res_valid in cycle 3; in_ready low from final term until result handshake.
module mac_4bit_seq
    import mac_seq_pkg::*;
#(
    parameter int MULTI_WIDTH = mac_seq_pkg::MULTI_WIDTH,
    parameter int CNT_WIDTH   = 8,
    parameter int MAX_TERMS   = 255
) (
    input  logic                   MAC_ACC_CLK,
    input  logic                   MAC_ACC_RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MULTI_WIDTH-1:0] in_oper,
    input  logic [MULTI_WIDTH-1:0] in_coef,
    input  logic                   in_last,
    input  logic [5:0]             cfg_out_sel,
    input  logic                   cfg_rnd,
    input  logic                   cfg_sat,
    input  logic                   cfg_tc,
    output logic [MULTI_WIDTH-1:0] MAC_OPER_DATA,
    output logic [MULTI_WIDTH-1:0] MAC_COEF_DATA,
    output logic                   EFPGA_MATHB_CLK_EN,
    output logic                   MAC_ACC_CLEAR,
    output logic                   MAC_ACC_RND,
    output logic                   MAC_ACC_SAT,
    output logic [5:0]             MAC_OUT_SEL,
    output logic                   MAC_TC,
    input  logic [MULTI_WIDTH-1:0] MAC_OUT,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [MULTI_WIDTH-1:0] res_data,
    output logic [CNT_WIDTH-1:0]   res_count,
    output logic                   res_trunc
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_TERMS);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

    seq_state_e             state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic [MULTI_WIDTH-1:0] oper_q, oper_d, coef_q, coef_d;
    logic                   en_q, en_d, clear_q, clear_d, rnd_q, rnd_d;
    logic                   sat_q, sat_d, tc_q, tc_d;
    logic [5:0]             out_sel_q, out_sel_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   trunc_q, trunc_d;
    logic                   res_valid_q, res_valid_d;
    logic [MULTI_WIDTH-1:0] res_data_q, res_data_d;
    logic [CNT_WIDTH-1:0]   res_count_q, res_count_d;
    logic                   res_trunc_q, res_trunc_d;
    logic                   accept;

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        oper_d      = oper_q;
        coef_d      = coef_q;
        en_d        = 1'b0;
        clear_d     = 1'b0;
        rnd_d       = 1'b0;
        sat_d       = sat_q;
        tc_d        = tc_q;
        out_sel_d   = out_sel_q;
        count_d     = count_q;
        trunc_d     = trunc_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        res_trunc_d = res_trunc_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    out_sel_d = cfg_out_sel;
                    sat_d     = cfg_sat;
                    tc_d      = cfg_tc;
                    oper_d    = in_oper;
                    coef_d    = in_coef;
                    en_d      = 1'b1;
                    // First product lands on zero or on the MAC's rounding constant.
                    clear_d   = ~cfg_rnd;
                    rnd_d     = cfg_rnd;
                    count_d   = ONE_CNT;
                    trunc_d   = 1'b0;
                    state_d   = RUN;
                    if (in_last || ONE_CNT == MAX_CNT) begin
                        state_d    = WAIT;
                        in_ready_d = 1'b0;
                        trunc_d    = ~in_last;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    oper_d  = in_oper;
                    coef_d  = in_coef;
                    en_d    = 1'b1;
                    count_d = count_q + ONE_CNT;
                    if (in_last || count_d == MAX_CNT) begin
                        state_d    = WAIT;
                        in_ready_d = 1'b0;
                        trunc_d    = ~in_last;
                    end
                end
            end
            WAIT: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                res_data_d  = MAC_OUT;
                res_count_d = count_q;
                res_trunc_d = trunc_q;
                res_valid_d = 1'b1;
                state_d     = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge MAC_ACC_CLK) begin
        if (MAC_ACC_RST) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            oper_q      <= '0;
            coef_q      <= '0;
            en_q        <= 1'b0;
            clear_q     <= 1'b0;
            rnd_q       <= 1'b0;
            sat_q       <= 1'b0;
            tc_q        <= 1'b0;
            out_sel_q   <= '0;
            count_q     <= '0;
            trunc_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            oper_q      <= oper_d;
            coef_q      <= coef_d;
            en_q        <= en_d;
            clear_q     <= clear_d;
            rnd_q       <= rnd_d;
            sat_q       <= sat_d;
            tc_q        <= tc_d;
            out_sel_q   <= out_sel_d;
            count_q     <= count_d;
            trunc_q     <= trunc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            res_trunc_q <= res_trunc_d;
        end
    end

    assign in_ready           = in_ready_q;
    assign MAC_OPER_DATA      = oper_q;
    assign MAC_COEF_DATA      = coef_q;
    assign EFPGA_MATHB_CLK_EN = en_q;
    assign MAC_ACC_CLEAR      = clear_q;
    assign MAC_ACC_RND        = rnd_q;
    assign MAC_ACC_SAT        = sat_q;
    assign MAC_OUT_SEL        = out_sel_q;
    assign MAC_TC             = tc_q;
    assign res_valid          = res_valid_q;
    assign res_data           = res_data_q;
    assign res_count          = res_count_q;
    assign res_trunc          = res_trunc_q;

endmodule
